mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory-side responder for cache line fills and writebacks requested by the cache controller.
- Accepts one 16-word line request at a time. Splits it into 16 single-word beats on the host memory port.
- For reads, it assembles the returned words into a line. Completion is signalled with the `ready`/`tx_done` pair the cache controller already consumes.

Parameters:
- LINE_WORDS, 16, words per cache line (power of two; beat counter width = log2(LINE_WORDS)).
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- MAX_OUTST, 16, max host read beats in flight (1..LINE_WORDS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  1  cache request strobe; accepted only when ready=1.
- req_wr  in  1  0 = line fill (read), 1 = writeback (write).
- req_addr  in  ADDR_W  line address; low log2(LINE_WORDS*4) bits ignored.
- req_wr_line  in  DATA_W x LINE_WORDS  writeback data, sampled at acceptance.
- ready  out  1  idle and able to accept a request.
- tx_done  out  1  one-cycle pulse when the accepted request is complete.
- rd_line  out  DATA_W x LINE_WORDS  filled line; valid from tx_done of a read.
- err  out  1  sticky protocol error; cleared only by rst.
- host_req_vld  out  1  host beat request valid.
- host_req_rdy  in  1  host accepts the beat when vld&rdy.
- host_req_wr  out  1  beat is a write.
- host_req_addr  out  ADDR_W  beat byte address.
- host_wr_data  out  DATA_W  beat write data.
- host_rsp_vld  in  1  read data beat valid; no back-pressure; responses return in order.
- host_rsp_data  in  DATA_W  read data.

Behaviour:
- Reset values: ready=1, tx_done=0, err=0, rd_line all zero, host_req_vld=0, counters=0, state=IDLE.
- Reset may occur mid-transfer: the transfer is abandoned, rd_line returns to zero, and no tx_done is produced.
- States: IDLE, RD_XFER, WR_XFER, DONE.
- IDLE:
  - ready=1.
  - On req_vld, latch the line base, req_wr and req_wr_line. Zero issue_cnt, rsp_cnt and outst.
  - Go to WR_XFER if req_wr=1, otherwise RD_XFER.
- Beat addressing: beat i address = {line_base[ADDR_W-1:6], i[3:0], 2'b00}.
- RD_XFER:
  - host_req_vld=1 while issue_cnt<LINE_WORDS and outst<MAX_OUTST. host_req_wr=0.
  - On host handshake: issue_cnt++.
  - On host_rsp_vld: rd_line[rsp_cnt] <= host_rsp_data, rsp_cnt++.
  - outst tracks issued minus returned; a handshake and a response in the same cycle leave it unchanged.
  - When the response taking rsp_cnt to LINE_WORDS arrives, go to DONE.
- WR_XFER:
  - host_req_vld=1, host_req_wr=1, host_wr_data = latched word[issue_cnt].
  - After the handshake with issue_cnt=LINE_WORDS-1, go to DONE. Writes are posted; no response is expected.
- DONE:
  - tx_done=1 for exactly one cycle, ready=0, then go to IDLE.
  - A new request is therefore accepted no earlier than 2 cycles after the last beat.
- ready=0 in every state except IDLE. req_vld while busy is ignored and not queued.
- host_req_vld holds, with stable address and data, until host_req_rdy.
- Boundary conditions:
  - host_rsp_vld in IDLE, WR_XFER or DONE, or with outst=0: response is dropped, err <= 1, state unaffected.
  - rd_line holds its value between reads and is not modified by writebacks.
  - Counter wrap is impossible by construction; the 16th beat exits the state.
- Minimum latency with host_req_rdy=1 and a 1-cycle response:
  - Read: acceptance at cycle 0, beats issued cycles 1..16, tx_done at cycle 18.
  - Write: acceptance at cycle 0, tx_done at cycle 17.

Decomposition:
- Shared package (mem_pkg): LINE_WORDS, WORD_BYTES, OFFSET_BITS constants.
- mem_pkg also holds the mem_state_t enum {IDLE, RD_XFER, WR_XFER, DONE} and a line_t type for the DATA_W x LINE_WORDS array, shared with the cache side.
- One natural sub-module: mem_beat_ctr, holding the issue, response and outstanding counters with its full/empty flags. The FSM and line buffer stay in mem_ctrl.

Test Plan:
- Read, host always ready, response the cycle after each beat, req_addr=0x0000_1234 -> beat addresses 0x1200..0x123C step 4; rd_line[i]=returned data; tx_done one pulse at cycle 18; ready back to 1 at cycle 19.
- Writeback to 0x0000_8000 with word i=0xA000_0000+i, host_req_rdy low on beats 3 and 9 for 2 cycles each -> address and data held stable while stalled; 16 write beats; tx_done at cycle 21; no err.
- MAX_OUTST=4 with host response delayed 5 cycles -> never more than 4 beats in flight; rd_line correct; tx_done once.
- req_vld asserted continuously during a read -> second request not accepted until the cycle after tx_done; exactly 2 tx_done pulses total.
- host_rsp_vld pulsed in IDLE -> err=1 and stays 1; a following read completes normally with correct rd_line.
- rst asserted at beat 7 of a read -> asynchronously ready=1, host_req_vld=0, rd_line=0; no tx_done; the next read completes correctly.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the memory-side line responder and the
// cache controller that talks to it.
//   LINE_WORDS  : words per cache line (power of two)
//   ADDR_W      : byte address width
//   DATA_W      : word width
//   WORD_BYTES  : bytes per word
//   OFFSET_BITS : byte-offset bits inside one line (ignored in line addresses)
//   mem_state_t : responder FSM state
//   line_t      : one full cache line, word 0 in the least significant slot
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int LINE_WORDS  = 16;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int WORD_BYTES  = DATA_W / 8;
  localparam int WORD_OFF    = $clog2(WORD_BYTES);
  localparam int BEAT_W      = $clog2(LINE_WORDS);
  localparam int OFFSET_BITS = BEAT_W + WORD_OFF;
  localparam int TAG_W       = ADDR_W - OFFSET_BITS;
  // One extra bit so the issue/response counters can hold LINE_WORDS itself.
  localparam int CNT_W       = BEAT_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_XFER = 2'd1,
    WR_XFER = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

  typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

  // Byte address of beat idx within the line identified by tag.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]  tag,
                                                  input logic [BEAT_W-1:0] idx);
    return {tag, idx, {WORD_OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// Interfaces of the memory-side line responder.
//
// mem_req_if  : cache controller <-> mem_ctrl (master = cache, slave = mem_ctrl)
//   req_vld / req_wr / req_addr / req_wr_line : line request, taken when ready=1
//   ready / tx_done / rd_line / err           : status and filled line
//
// mem_host_if : mem_ctrl <-> host memory port (master = mem_ctrl, slave = host)
//   host_req_vld / host_req_rdy / host_req_wr / host_req_addr / host_wr_data
//   host_rsp_vld / host_rsp_data
//
// Handshake rules: a beat transfers on the rising edge where host_req_vld and
// host_req_rdy are both 1. Once host_req_vld is raised it stays high with
// address, write flag and data unchanged until that edge. host_rsp_vld has no
// back-pressure and responses return in request order. On the cache side a
// request is taken on the edge where req_vld and ready are both 1; req_vld
// while ready=0 is dropped, not queued.
// -----------------------------------------------------------------------------
interface mem_req_if;
  import mem_pkg::*;

  logic              req_vld;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  line_t             req_wr_line;
  logic              ready;
  logic              tx_done;
  line_t             rd_line;
  logic              err;

  modport master (
    output req_vld, req_wr, req_addr, req_wr_line,
    input  ready, tx_done, rd_line, err
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wr_line,
    output ready, tx_done, rd_line, err
  );
endinterface

interface mem_host_if;
  import mem_pkg::*;

  logic              host_req_vld;
  logic              host_req_rdy;
  logic              host_req_wr;
  logic [ADDR_W-1:0] host_req_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_rsp_vld;
  logic [DATA_W-1:0] host_rsp_data;

  modport master (
    output host_req_vld, host_req_wr, host_req_addr, host_wr_data,
    input  host_req_rdy, host_rsp_vld, host_rsp_data
  );

  modport slave (
    input  host_req_vld, host_req_wr, host_req_addr, host_wr_data,
    output host_req_rdy, host_rsp_vld, host_rsp_data
  );
endinterface

// File: rtl/mem_beat_ctr.sv
// -----------------------------------------------------------------------------
// mem_beat_ctr
// Beat bookkeeping for one line transfer: beats issued, responses received and
// reads in flight.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear (held while the responder is idle)
//   issue        : a host beat handshake happens this cycle
//   rsp          : an accepted read response arrives this cycle
//   issue_cnt    : beats issued so far (0..LINE_WORDS)
//   rsp_cnt      : responses received so far (0..LINE_WORDS)
//   issue_full   : all LINE_WORDS beats issued
//   outst_full   : MAX_OUTST beats in flight, no further issue allowed
//   outst_empty  : nothing in flight, a response now would be spurious
// -----------------------------------------------------------------------------
module mem_beat_ctr
  import mem_pkg::*;
#(
  parameter int MAX_OUTST = LINE_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             issue,
  input  logic             rsp,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] rsp_cnt,
  output logic             issue_full,
  output logic             outst_full,
  output logic             outst_empty
);

  logic [CNT_W-1:0] outst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      rsp_cnt   <= '0;
      outst     <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      rsp_cnt   <= '0;
      outst     <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
      if (rsp)   rsp_cnt   <= rsp_cnt + CNT_W'(1);
      // Issue and response in the same cycle cancel out.
      if (issue && !rsp)      outst <= outst + CNT_W'(1);
      else if (rsp && !issue) outst <= outst - CNT_W'(1);
    end
  end

  assign issue_full  = (issue_cnt == CNT_W'(LINE_WORDS));
  assign outst_full  = (outst >= CNT_W'(MAX_OUTST));
  assign outst_empty = (outst == '0);

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Memory-side responder for cache line fills and writebacks. Takes one
// LINE_WORDS-word line request at a time, splits it into single-word beats on
// the host port and, for fills, assembles the returned words into rd_line.
//   clk, rst  : clock, asynchronous active-high reset (abandons any transfer)
//   req       : cache side (req_vld/req_wr/req_addr/req_wr_line in;
//               ready/tx_done/rd_line/err out)
//   host      : host memory port (beat request out, read response in)
//   dbg_state : current FSM state
// err is sticky: it is set by any response that arrives when no read beat is
// outstanding and is cleared only by rst.
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int MAX_OUTST = LINE_WORDS
) (
  input  logic            clk,
  input  logic            rst,
  mem_req_if.slave        req,
  mem_host_if.master      host,
  output mem_state_t      dbg_state
);

  mem_state_t        state;
  logic              ready_q;
  logic              tx_done_q;
  logic              err_q;
  logic [TAG_W-1:0]  line_tag;
  line_t             wr_buf;
  line_t             rd_buf;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rsp_cnt;
  logic              issue_full;
  logic              outst_full;
  logic              outst_empty;
  logic              beat_hs;
  logic              rsp_ok;
  logic              ctr_clr;
  logic [BEAT_W-1:0] issue_idx;
  logic [BEAT_W-1:0] rsp_idx;

  assign issue_idx = issue_cnt[BEAT_W-1:0];
  assign rsp_idx   = rsp_cnt[BEAT_W-1:0];
  assign beat_hs   = host.host_req_vld && host.host_req_rdy;
  // Only a response to an outstanding read beat is kept; anything else is
  // dropped and flagged.
  assign rsp_ok    = host.host_rsp_vld && (state == RD_XFER) && !outst_empty;
  // Counters sit at zero whenever idle, so they start clean on acceptance.
  assign ctr_clr   = (state == IDLE);

  mem_beat_ctr #(.MAX_OUTST(MAX_OUTST)) u_beat_ctr (
    .clk         (clk),
    .rst         (rst),
    .clr         (ctr_clr),
    .issue       (beat_hs),
    .rsp         (rsp_ok),
    .issue_cnt   (issue_cnt),
    .rsp_cnt     (rsp_cnt),
    .issue_full  (issue_full),
    .outst_full  (outst_full),
    .outst_empty (outst_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
      line_tag  <= '0;
      wr_buf    <= '0;
      rd_buf    <= '0;
    end else begin
      tx_done_q <= 1'b0;

      if (host.host_rsp_vld && !rsp_ok) err_q <= 1'b1;
      if (rsp_ok) rd_buf[rsp_idx] <= host.host_rsp_data;

      case (state)
        IDLE: begin
          if (req.req_vld) begin
            line_tag <= req.req_addr[ADDR_W-1:OFFSET_BITS];
            wr_buf   <= req.req_wr_line;
            ready_q  <= 1'b0;
            state    <= req.req_wr ? WR_XFER : RD_XFER;
          end
        end
        RD_XFER: begin
          if (rsp_ok && (rsp_cnt == CNT_W'(LINE_WORDS - 1))) begin
            state     <= DONE;
            tx_done_q <= 1'b1;
          end
        end
        WR_XFER: begin
          // Writes are posted: the last handshake ends the transfer.
          if (beat_hs && (issue_cnt == CNT_W'(LINE_WORDS - 1))) begin
            state     <= DONE;
            tx_done_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Beat request is a function of registered state only; issue_cnt does not
  // move until the handshake and outst can only fall while a beat waits, so
  // valid, address and data stay stable while the host stalls.
  assign host.host_req_vld  = ((state == RD_XFER) && !issue_full && !outst_full) ||
                              (state == WR_XFER);
  assign host.host_req_wr   = (state == WR_XFER);
  assign host.host_req_addr = beat_addr(line_tag, issue_idx);
  assign host.host_wr_data  = wr_buf[issue_idx];

  assign req.ready   = ready_q;
  assign req.tx_done = tx_done_q;
  assign req.rd_line = rd_buf;
  assign req.err     = err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int MAX_OUTST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_if  req_if();
  mem_host_if host_if();
  mem_state_t dbg_state;

  mem_ctrl #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req_if),
    .host      (host_if),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int rsp_delay = 1;
  bit stall_en = 1'b0;
  bit inject = 1'b0;
  logic [DATA_W-1:0] salt = '0;

  logic              hs_seen = 1'b0;
  logic              hs_wr = 1'b0;
  logic [ADDR_W-1:0] hs_addr = '0;
  int                due_q[$];
  logic [DATA_W-1:0] dat_q[$];
  int                inflight = 0;
  int                max_inflight = 0;
  int                stall_left = 2;

  logic [ADDR_W-1:0] beat_addr_q[$];
  logic              beat_wr_q[$];
  logic [DATA_W-1:0] beat_data_q[$];
  int                beat_cyc_q[$];
  int                acc_q[$];
  int                done_q[$];
  int                done_cnt = 0;
  int                rdy_cyc = 0;
  logic              ready_prev = 1'b1;
  logic              stalled = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;

  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- observer (mid-cycle) ----------------
  // Cycle numbers recorded here are the rising edge that samples the event.
  always @(negedge clk) begin
    hs_seen = host_if.host_req_vld && host_if.host_req_rdy;
    hs_wr   = host_if.host_req_wr;
    hs_addr = host_if.host_req_addr;
    if (hs_seen) begin
      beat_addr_q.push_back(host_if.host_req_addr);
      beat_wr_q.push_back(host_if.host_req_wr);
      beat_data_q.push_back(host_if.host_wr_data);
      beat_cyc_q.push_back(cyc + 1);
    end
    if (stalled) begin
      chk("stall_vld",  host_if.host_req_vld,  1'b1);
      chk("stall_addr", host_if.host_req_addr, st_addr);
      chk("stall_data", host_if.host_wr_data,  st_data);
    end
    stalled = host_if.host_req_vld && !host_if.host_req_rdy;
    st_addr = host_if.host_req_addr;
    st_data = host_if.host_wr_data;
    if (req_if.req_vld && req_if.ready) acc_q.push_back(cyc + 1);
    if (req_if.tx_done) begin
      done_cnt++;
      done_q.push_back(cyc + 1);
    end
    if (req_if.ready && !ready_prev) rdy_cyc = cyc + 1;
    ready_prev = req_if.ready;
  end

  // ---------------- host memory model ----------------
  // Read data is the beat address XOR salt, returned rsp_delay cycles after
  // the handshake. Beats with word index 3 and 9 are stalled 2 cycles when
  // stall_en is set.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (host_if.host_rsp_vld && !inject) inflight--;
      if (hs_seen && !hs_wr) begin
        inflight++;
        due_q.push_back(cyc + rsp_delay - 1);
        dat_q.push_back(hs_addr ^ salt);
      end
      if (inflight > max_inflight) max_inflight = inflight;
      if (hs_seen) stall_left = 2;
    end
    #2;
    if (rst) begin
      due_q.delete();
      dat_q.delete();
      inflight = 0;
      host_if.host_rsp_vld  = 1'b0;
      host_if.host_rsp_data = '0;
      host_if.host_req_rdy  = 1'b1;
    end else begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        host_if.host_rsp_vld  = 1'b1;
        host_if.host_rsp_data = dat_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        host_if.host_rsp_vld  = inject;
        host_if.host_rsp_data = 32'hDEAD_0000;
      end
      if (stall_en && host_if.host_req_vld && stall_left > 0 &&
          (host_if.host_req_addr[5:2] == 4'd3 || host_if.host_req_addr[5:2] == 4'd9)) begin
        host_if.host_req_rdy = 1'b0;
        stall_left--;
      end else begin
        host_if.host_req_rdy = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    beat_addr_q.delete();
    beat_wr_q.delete();
    beat_data_q.delete();
    beat_cyc_q.delete();
    acc_q.delete();
    done_q.delete();
  endtask

  task automatic issue_req(input logic wr, input logic [ADDR_W-1:0] addr, input line_t line);
    req_if.req_vld     = 1'b1;
    req_if.req_wr      = wr;
    req_if.req_addr    = addr;
    req_if.req_wr_line = line;
    tick(1);
    req_if.req_vld = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, done_cnt >= target, 1'b1);
  endtask

  task automatic chk_beats(input string tag, input logic wr,
                           input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] wbase);
    chk({tag, "_nbeats"}, beat_addr_q.size(), LINE_WORDS);
    exp_q.delete();
    for (int i = 0; i < LINE_WORDS; i++) exp_q.push_back(base + ADDR_W'(4 * i));
    for (int i = 0; i < LINE_WORDS && i < beat_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), beat_addr_q[i], exp_q.pop_front());
      chk($sformatf("%s_wr%0d", tag, i), beat_wr_q[i], wr);
      if (wr) chk($sformatf("%s_data%0d", tag, i), beat_data_q[i], wbase + DATA_W'(i));
    end
  endtask

  task automatic chk_line(input string tag, input logic [ADDR_W-1:0] base);
    exp_q.delete();
    for (int i = 0; i < LINE_WORDS; i++) exp_q.push_back((base + ADDR_W'(4 * i)) ^ salt);
    for (int i = 0; i < LINE_WORDS; i++)
      chk($sformatf("%s_rd_line%0d", tag, i), req_if.rd_line[i], exp_q.pop_front());
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int n;
    line_t wl;

    rst = 1'b1;
    req_if.req_vld     = 1'b0;
    req_if.req_wr      = 1'b0;
    req_if.req_addr    = '0;
    req_if.req_wr_line = '0;
    tick(3);

    // Reset values
    chk("rst_ready",   req_if.ready,         1'b1);
    chk("rst_tx_done", req_if.tx_done,       1'b0);
    chk("rst_err",     req_if.err,           1'b0);
    chk("rst_rd_line", req_if.rd_line,       '0);
    chk("rst_hvld",    host_if.host_req_vld, 1'b0);
    chk("rst_state",   dbg_state,            IDLE);
    rst = 1'b0;
    tick(2);

    // T1: read 0x1234, host always ready, 1-cycle response
    salt = 32'h5A5A_0000;
    rsp_delay = 1;
    clear_logs();
    d0 = done_cnt;
    issue_req(1'b0, 32'h0000_1234, '0);
    wait_done(d0 + 1, 100, "t1_done_seen");
    tick(3);
    chk("t1_acc", acc_q.size(), 1);
    chk_beats("t1", 1'b0, 32'h0000_1200, '0);
    chk("t1_first_beat", beat_cyc_q[0] - acc_q[0], 1);
    chk("t1_last_beat",  beat_cyc_q[15] - acc_q[0], 16);
    chk("t1_done_cyc",   done_q[0] - acc_q[0], 18);
    chk("t1_ready_cyc",  rdy_cyc - acc_q[0], 19);
    chk("t1_done_cnt",   done_cnt - d0, 1);
    chk("t1_err",        req_if.err, 1'b0);
    chk_line("t1", 32'h0000_1200);

    // T2: writeback 0x8000 with stalls on beats 3 and 9
    for (int i = 0; i < LINE_WORDS; i++) wl[i] = 32'hA000_0000 + DATA_W'(i);
    stall_en = 1'b1;
    clear_logs();
    d0 = done_cnt;
    issue_req(1'b1, 32'h0000_8000, wl);
    wait_done(d0 + 1, 100, "t2_done_seen");
    stall_en = 1'b0;
    tick(3);
    chk_beats("t2", 1'b1, 32'h0000_8000, 32'hA000_0000);
    chk("t2_done_cyc", done_q[0] - acc_q[0], 21);
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_err",      req_if.err, 1'b0);
    chk_line("t2_keep", 32'h0000_1200);

    // T3: response delayed 5 cycles, at most MAX_OUTST reads in flight
    salt = 32'h0F0F_3C3C;
    rsp_delay = 5;
    max_inflight = 0;
    clear_logs();
    d0 = done_cnt;
    issue_req(1'b0, 32'h0000_447C, '0);
    wait_done(d0 + 1, 200, "t3_done_seen");
    tick(8);
    chk("t3_max_inflight", max_inflight, MAX_OUTST);
    chk("t3_inflight_end", inflight, 0);
    chk_beats("t3", 1'b0, 32'h0000_4440, '0);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk("t3_err",      req_if.err, 1'b0);
    chk_line("t3", 32'h0000_4440);

    // T4: req_vld held high across a read
    salt = 32'h1111_2222;
    rsp_delay = 1;
    clear_logs();
    d0 = done_cnt;
    req_if.req_vld  = 1'b1;
    req_if.req_wr   = 1'b0;
    req_if.req_addr = 32'h0000_2000;
    n = 0;
    while (done_cnt < d0 + 2 && n < 200) begin
      tick(1);
      n++;
    end
    req_if.req_vld = 1'b0;
    chk("t4_two_done_seen", done_cnt >= d0 + 2, 1'b1);
    tick(25);
    chk("t4_done_cnt", done_cnt - d0, 2);
    chk("t4_acc_cnt",  acc_q.size(), 2);
    chk("t4_acc2_cyc", acc_q[1] - done_q[0], 1);
    chk_line("t4", 32'h0000_2000);

    // T5: spurious response while idle
    d0 = done_cnt;
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(3);
    chk("t5_err",      req_if.err, 1'b1);
    chk("t5_state",    dbg_state, IDLE);
    chk("t5_ready",    req_if.ready, 1'b1);
    chk("t5_no_done",  done_cnt - d0, 0);
    chk_line("t5_keep", 32'h0000_2000);
    salt = 32'hCAFE_0000;
    clear_logs();
    issue_req(1'b0, 32'h0000_3000, '0);
    wait_done(d0 + 1, 100, "t5_done_seen");
    tick(3);
    chk("t5_err_sticky", req_if.err, 1'b1);
    chk("t5_done_cnt",   done_cnt - d0, 1);
    chk_line("t5", 32'h0000_3000);

    // T6: reset in the middle of a read
    salt = 32'h7777_0101;
    clear_logs();
    d0 = done_cnt;
    issue_req(1'b0, 32'h0000_5000, '0);
    n = 0;
    while (beat_addr_q.size() < 7 && n < 50) begin
      tick(1);
      n++;
    end
    chk("t6_beat7_seen", beat_addr_q.size() >= 7, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_ready",   req_if.ready,         1'b1);
    chk("t6_async_hvld",    host_if.host_req_vld, 1'b0);
    chk("t6_async_rd_line", req_if.rd_line,       '0);
    chk("t6_async_state",   dbg_state,            IDLE);
    chk("t6_async_err",     req_if.err,           1'b0);
    tick(2);
    rst = 1'b0;
    tick(25);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_err",     req_if.err, 1'b0);
    salt = 32'h0BEE_F00D;
    clear_logs();
    issue_req(1'b0, 32'h0000_6000, '0);
    wait_done(d0 + 1, 100, "t6_done_seen");
    tick(3);
    chk_beats("t6", 1'b0, 32'h0000_6000, '0);
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk_line("t6", 32'h0000_6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
